fizzle_ctrl: RTL and testbench

- Sequences a full-screen fizzle (dissolve) transition by writing the fizzlebuffer, a 1-bit-per-pixel BRAM that is read in lockstep with the framebuffer.
- Waits a programmable number of frames after `start`, then walks every fizzlebuffer address exactly once in pseudo-random order at a fixed rate, and reports `done`.
- Sits between display timing (frame pulse, blanking) and the fizzlebuffer write port. It replaces ad-hoc top-level counters.

---
 rtl/fizzle_pkg.sv | 28 ++
 rtl/fizzle_ctrl_lfsr.sv | 53 +++++
 rtl/fizzle_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_fizzle_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fizzle_pkg.sv
// -----------------------------------------------------------------------------
// fizzle_pkg
// Shared types and default constants for the fizzle transition controller.
//   fizzle_state_t : controller state encoding (IDLE, WAIT, FADE, DONE)
//   FZ_LFSR_LEN    : default LFSR width / fizzlebuffer address width
//   FZ_TAPS        : default maximal-length Galois tap mask for FZ_LFSR_LEN
//   FZ_PIXELS      : default fizzlebuffer depth
//   cnt_width()    : bits needed to hold 0..n, never less than one bit
// -----------------------------------------------------------------------------
package fizzle_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    FADE = 2'd2,
    DONE = 2'd3
  } fizzle_state_t;

  localparam int          FZ_LFSR_LEN = 15;
  localparam logic [14:0] FZ_TAPS     = 15'b110000000000000;
  localparam int          FZ_PIXELS   = 19200;

  // A zero-valued count still needs a one-bit register to exist.
  function automatic int cnt_width(input int n);
    return (n <= 0) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/fizzle_ctrl_lfsr.sv
// -----------------------------------------------------------------------------
// fizzle_ctrl_lfsr
// Right-shifting Galois LFSR used as the fizzle address generator. The reset
// state and the local load value are both SEED, so a reload restarts the
// exact same sequence that follows reset.
// Ports:
//   clk    in   clock
//   rst    in   asynchronous active-high reset (loads SEED)
//   ld     in   synchronous reload of SEED (has priority over en)
//   en     in   advance one step
//   q      out  current state
//   q_next out  state after the next advance (combinational)
// -----------------------------------------------------------------------------
module fizzle_ctrl_lfsr
  import fizzle_pkg::*;
#(
  parameter int             LEN  = FZ_LFSR_LEN,
  parameter logic [LEN-1:0] TAPS = LEN'(FZ_TAPS),
  parameter logic [LEN-1:0] SEED = LEN'(1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ld,
  input  logic           en,
  output logic [LEN-1:0] q,
  output logic [LEN-1:0] q_next
);

  logic [LEN-1:0] r_q;

  // Galois step: shift right, fold the taps in when a one drops out.
  always_comb begin
    if (r_q[0]) begin
      q_next = (r_q >> 1) ^ TAPS;
    end else begin
      q_next = r_q >> 1;
    end
  end

  // State register: reload wins over advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= SEED;
    end else if (ld) begin
      r_q <= SEED;
    end else if (en) begin
      r_q <= q_next;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/fizzle_ctrl.sv
// -----------------------------------------------------------------------------
// fizzle_ctrl
// Sequences a full-screen fizzle transition: after start it waits WAIT_FRAMES
// frame pulses, then writes every fizzlebuffer address exactly once in LFSR
// order, one valid pixel per RATE clocks, and finally reports done.
// Candidates beyond the buffer depth are skipped at one per clock.
// Optional build macro: FIZZLE_BLANK_ONLY_EN -- writes and skips only happen
// while blank is high; an expired write waits for blanking.
// Ports:
//   clk      in   pixel clock
//   rst_n    in   asynchronous active-low reset
//   start    in   one-cycle request, honoured in IDLE and DONE
//   abort    in   return to IDLE next cycle, from any state
//   dir      in   value written to every pixel, latched on accepted start
//   frame    in   one-cycle pulse at start of vertical blanking
//   blank    in   blanking level (used only with FIZZLE_BLANK_ONLY_EN)
//   fz_we    out  fizzlebuffer write enable (one clock per pixel)
//   fz_addr  out  fizzlebuffer write address
//   fz_data  out  fizzlebuffer write data
//   busy     out  high in WAIT and FADE
//   done     out  high in DONE
// -----------------------------------------------------------------------------
module fizzle_ctrl
  import fizzle_pkg::*;
#(
  parameter int                  LFSR_LEN    = FZ_LFSR_LEN,
  parameter logic [LFSR_LEN-1:0] LFSR_TAPS   = LFSR_LEN'(FZ_TAPS),
  parameter logic [LFSR_LEN-1:0] LFSR_SEED   = LFSR_LEN'(1),
  parameter int                  PIXELS      = FZ_PIXELS,
  parameter int                  WAIT_FRAMES = 600,
  parameter int                  RATE        = 3200
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic                dir,
  input  logic                frame,
  input  logic                blank,
  output logic                fz_we,
  output logic [LFSR_LEN-1:0] fz_addr,
  output logic                fz_data,
  output logic                busy,
  output logic                done
);

  localparam int FCW = cnt_width(WAIT_FRAMES);
  localparam int RCW = cnt_width(RATE);
  localparam logic [FCW-1:0]      FC_LAST = (WAIT_FRAMES == 0) ? FCW'(0) : FCW'(WAIT_FRAMES - 1);
  localparam logic [RCW-1:0]      RC_LAST = RCW'(RATE - 1);
  localparam logic [LFSR_LEN-1:0] PIX_LIM = LFSR_LEN'(PIXELS);

  fizzle_state_t       r_state;
  logic [FCW-1:0]      r_frame_cnt;
  logic [RCW-1:0]      r_rate_cnt;
  logic                r_dir;
  logic                r_fz_we;
  logic [LFSR_LEN-1:0] r_fz_addr;
  logic                r_fz_data;
  logic                r_busy;
  logic                r_done;

  logic [LFSR_LEN-1:0] w_lfsr_q;
  logic [LFSR_LEN-1:0] w_lfsr_next;
  logic [LFSR_LEN-1:0] w_cand;
  logic                w_skip;
  logic                w_expire;
  logic                w_gate;
  logic                w_adv;
  logic                w_load;
  logic                w_last;
  logic                w_rst;
  logic                w_unused;

  assign w_rst = ~rst_n;

  fizzle_ctrl_lfsr #(
    .LEN  (LFSR_LEN),
    .TAPS (LFSR_TAPS),
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk    (clk),
    .rst    (w_rst),
    .ld     (w_load),
    .en     (w_adv),
    .q      (w_lfsr_q),
    .q_next (w_lfsr_next)
  );

`ifdef FIZZLE_BLANK_ONLY_EN
  assign w_gate   = blank;
  assign w_unused = 1'b0;
`else
  assign w_gate   = 1'b1;
  assign w_unused = blank;
`endif

  // Candidate decode and LFSR control strobes.
  always_comb begin
    // The LFSR never holds zero, so state-1 covers addresses 0..2^LEN-2.
    w_cand   = w_lfsr_q - LFSR_LEN'(1);
    w_skip   = (w_cand >= PIX_LIM);
    w_expire = (r_rate_cnt == RC_LAST);
    w_last   = (w_lfsr_next == LFSR_SEED);
    w_adv    = (r_state == FADE) && !abort && w_gate && (w_skip || w_expire);
    w_load   = !abort && start && ((r_state == IDLE) || (r_state == DONE));
  end

  // Controller FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_frame_cnt <= '0;
      r_rate_cnt  <= '0;
      r_dir       <= 1'b0;
      r_fz_we     <= 1'b0;
      r_fz_addr   <= '0;
      r_fz_data   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_fz_we <= 1'b0;
      if (abort) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
        r_done  <= 1'b0;
      end else begin
        case (r_state)
          IDLE, DONE: begin
            if (start) begin
              r_dir       <= dir;
              r_frame_cnt <= '0;
              r_rate_cnt  <= '0;
              r_busy      <= 1'b1;
              r_done      <= 1'b0;
              r_state     <= (WAIT_FRAMES == 0) ? FADE : WAIT;
            end
          end
          WAIT: begin
            if (frame) begin
              r_frame_cnt <= r_frame_cnt + FCW'(1);
              if (r_frame_cnt == FC_LAST) begin
                r_rate_cnt <= '0;
                r_state    <= FADE;
              end
            end
          end
          FADE: begin
            // Counting continues outside blanking; only the expiry waits.
            if (!w_skip && !w_expire) begin
              r_rate_cnt <= r_rate_cnt + RCW'(1);
            end else if (w_gate) begin
              if (!w_skip) begin
                r_fz_we    <= 1'b1;
                r_fz_addr  <= w_cand;
                r_fz_data  <= r_dir;
                r_rate_cnt <= '0;
              end
              // Wrapping back to the seed means every candidate has been seen.
              if (w_last) begin
                r_state <= DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end
            end
          end
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign fz_we   = r_fz_we;
  assign fz_addr = r_fz_addr;
  assign fz_data = r_fz_data;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule

// File: tb/tb_fizzle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fizzle_ctrl
// Directed bench for fizzle_ctrl with a 5-bit LFSR (taps 5'b10100, seed 1),
// 20 pixels, 2 wait frames and 4 clocks per write. A second instance with
// WAIT_FRAMES=0 covers the direct start-to-FADE path. Expected write order
// and skip counts were worked out by hand from the LFSR sequence
// 1,20,10,5,22,11,17,28,14,7,23,31,27,25,24,12,6,3,21,30,15,19,29,26,13,18,
// 9,16,8,4,2.
// -----------------------------------------------------------------------------
module tb_fizzle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, start, start0, abort, dir, frame, blank;
  logic       fz_we, fz_data, busy, done;
  logic [4:0] fz_addr;
  logic       we0, data0, busy0, done0;
  logic [4:0] addr0;

  int n_checks = 0;
  int n_fail   = 0;

  int exp_addr [20] = '{0, 19, 9, 4, 10, 16, 13, 6, 11, 5, 2, 14, 18, 12, 17, 8, 15, 7, 3, 1};
  int exp_skip [20] = '{0, 0, 0, 0, 1, 0, 1, 0, 5, 0, 0, 2, 0, 2, 0, 0, 0, 0, 0, 0};

  always #5 clk = ~clk;

  fizzle_ctrl #(
    .LFSR_LEN(5), .LFSR_TAPS(5'b10100), .LFSR_SEED(5'd1),
    .PIXELS(20), .WAIT_FRAMES(2), .RATE(4)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .dir(dir),
    .frame(frame), .blank(blank), .fz_we(fz_we), .fz_addr(fz_addr),
    .fz_data(fz_data), .busy(busy), .done(done)
  );

  fizzle_ctrl #(
    .LFSR_LEN(5), .LFSR_TAPS(5'b10100), .LFSR_SEED(5'd1),
    .PIXELS(20), .WAIT_FRAMES(0), .RATE(4)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort), .dir(dir),
    .frame(frame), .blank(blank), .fz_we(we0), .fz_addr(addr0),
    .fz_data(data0), .busy(busy0), .done(done0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic frame_pulse();
    frame = 1'b1;
    step();
    frame = 1'b0;
  endtask

  initial begin
    int wc;
    int gap;
    int extra;
    int n;
    rst_n = 1'b0; start = 1'b0; start0 = 1'b0; abort = 1'b0;
    dir = 1'b0; frame = 1'b0; blank = 1'b1;

    // Reset state
    step();
    check("rst_we", fz_we, 0);
    check("rst_addr", fz_addr, 0);
    check("rst_data", fz_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_busy0", busy0, 0);
    rst_n = 1'b1;
    step();

    // WAIT_FRAMES=0 instance: start goes straight to FADE
    dir = 1'b1;
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    check("wf0_busy", busy0, 1);
    for (int k = 1; k <= 4; k++) begin
      step();
      if (k < 4) check("wf0_we_early", we0, 0);
    end
    check("wf0_we", we0, 1);
    check("wf0_addr", addr0, 0);
    check("wf0_data", data0, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("wf0_abort_busy", busy0, 0);

    // Reset in the middle of FADE
    start = 1'b1;
    step();
    start = 1'b0;
    frame_pulse();
    frame_pulse();
    step();
    step();
    rst_n = 1'b0;
    #1;
    check("midrst_we", fz_we, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    step();
    rst_n = 1'b1;
    step();

    // Full run, dir=1
    dir = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_done", done, 0);
    frame_pulse();
    check("wait1_busy", busy, 1);
    check("wait1_we", fz_we, 0);
    // start in WAIT must not clear the frame count
    start = 1'b1;
    step();
    start = 1'b0;
    check("wait_start_busy", busy, 1);
    frame_pulse();
    for (int k = 1; k <= 4; k++) begin
      step();
      if (k < 4) check("first_we_early", fz_we, 0);
    end
    check("first_we", fz_we, 1);
    check("first_addr", fz_addr, 0);
    check("first_data", fz_data, 1);
    wc = 1;
    gap = 0;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      frame = (cyc == 10 || cyc == 50);
      start = (cyc == 30);
      step();
      frame = 1'b0;
      start = 1'b0;
      gap++;
      if (fz_we === 1'b1) begin
        check("run_addr", fz_addr, exp_addr[wc]);
        check("run_gap", gap, 4 + exp_skip[wc]);
        check("run_data", fz_data, 1);
        wc++;
        gap = 0;
        if (wc == 20) begin
          check("run_done", done, 1);
          check("run_busy_end", busy, 0);
          break;
        end
      end
    end
    check("run_write_count", wc, 20);

    // DONE holds and ignores frame
    extra = 0;
    for (int i = 0; i < 30; i++) begin
      frame = (i % 7 == 0);
      step();
      frame = 1'b0;
      if (fz_we !== 1'b0) extra++;
    end
    check("done_no_writes", extra, 0);
    check("done_hold", done, 1);
    check("done_busy", busy, 0);

    // Restart from DONE with dir=0, abort after 7 writes
    dir = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    check("restart_busy", busy, 1);
    check("restart_done", done, 0);
    frame_pulse();
    frame_pulse();
    wc = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      step();
      if (fz_we === 1'b1) begin
        check("out_data", fz_data, 0);
        wc++;
        if (wc == 7) break;
      end
    end
    check("abort_pre_count", wc, 7);
    // 5 skips plus 3 counts later the 8th write would expire; abort on it
    repeat (8) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_we", fz_we, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (fz_we !== 1'b0) extra++;
    end
    check("idle_no_writes", extra, 0);

    // Start after abort: reseeded LFSR gives address 0 first
    dir = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    check("reseed_busy", busy, 1);
    frame_pulse();
    frame_pulse();
    n = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (fz_we === 1'b1) begin
        n = i;
        break;
      end
    end
    check("reseed_latency", n, 4);
    check("reseed_addr", fz_addr, 0);
    abort = 1'b1;
    step();
    abort = 1'b0;

`ifdef FIZZLE_BLANK_ONLY_EN
    // Writes pend outside blanking
    start = 1'b1;
    step();
    start = 1'b0;
    frame_pulse();
    frame_pulse();
    blank = 1'b0;
    extra = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (fz_we !== 1'b0) extra++;
    end
    check("blank_no_writes", extra, 0);
    blank = 1'b1;
    step();
    check("blank_pending_we", fz_we, 1);
    check("blank_pending_addr", fz_addr, 0);
    wc = 1;
    for (int cyc = 0; cyc < 300; cyc++) begin
      step();
      if (fz_we === 1'b1) begin
        if (wc == 1) check("blank_second_addr", fz_addr, 19);
        wc++;
        if (wc == 20) break;
      end
    end
    check("blank_write_count", wc, 20);
    check("blank_done", done, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
